// File: rtl/vend_pkg.sv
// Shared definitions for the vend sequencer.
//
// Contents:
//   COIN_*      2-bit coin codes as delivered by the coin acceptor
//   state_t     controller states (2-bit encoding)
//   coin_value  maps a coin code to its worth in nickel units
package vend_pkg;

    localparam logic [1:0] COIN_NONE    = 2'b00;
    localparam logic [1:0] COIN_NICKEL  = 2'b01;
    localparam logic [1:0] COIN_DIME    = 2'b10;
    localparam logic [1:0] COIN_QUARTER = 2'b11;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'b00,
        ST_VEND    = 2'b01,
        ST_CHANGE  = 2'b10
    } state_t;

    // An invalid code is worth nothing; the caller flags it as a reject.
    function automatic logic [2:0] coin_value(input logic [1:0] code);
        logic [2:0] value;
        value = 3'd0;
        case (code)
            COIN_NICKEL:  value = 3'd1;
            COIN_DIME:    value = 3'd2;
            COIN_QUARTER: value = 3'd5;
            default:      value = 3'd0;
        endcase
        return value;
    endfunction

endpackage

// File: rtl/vend_sequencer.sv
// Coin-operated vend controller.
//
// Collects coins over a valid/ready handshake, accumulates credit in nickel
// units, runs one dispense handshake once the price is reached, then pays
// out the remainder one nickel per change handshake. Cancel during
// collection refunds the whole credit through the change path.
//
// Ports:
//   clock, reset       rising-edge clock, synchronous active-high reset
//   coin_valid/ready   coin handshake; coin_code selects the coin type
//   cancel             refund request, sampled each cycle
//   dispense_req/ack   one-item dispenser handshake
//   change_req/ack     one-nickel changer handshake
//   credit             current credit in nickels
//   coin_reject        one-cycle pulse after an accepted code-00 coin
//   sale_done          one-cycle pulse after a completed dispense
module vend_sequencer
    import vend_pkg::*;
#(
    parameter int PRICE_NICKELS = 3,
    parameter int CREDIT_W      = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                coin_valid,
    input  logic [1:0]          coin_code,
    output logic                coin_ready,
    input  logic                cancel,
    output logic                dispense_req,
    input  logic                dispense_ack,
    output logic                change_req,
    input  logic                change_ack,
    output logic [CREDIT_W-1:0] credit,
    output logic                coin_reject,
    output logic                sale_done
);

    localparam logic [CREDIT_W-1:0] PRICE = CREDIT_W'(PRICE_NICKELS);

    state_t              state, state_next;
    logic [CREDIT_W-1:0] credit_q, credit_next;
    logic                reject_q, reject_next;
    logic                sale_q, sale_next;

    // Next-state and next-credit logic. In COLLECT the routing decision
    // looks at the credit including this cycle's coin, so a coin arriving
    // together with cancel is refunded too, and cancel beats reaching the
    // price.
    always_comb begin
        state_next  = state;
        credit_next = credit_q;
        reject_next = 1'b0;
        sale_next   = 1'b0;
        case (state)
            ST_COLLECT: begin
                if (coin_valid) begin
                    if (coin_code == COIN_NONE) begin
                        reject_next = 1'b1;
                    end else begin
                        credit_next = credit_q + CREDIT_W'(coin_value(coin_code));
                    end
                end
                if (cancel && (credit_next != '0)) begin
                    state_next = ST_CHANGE;
                end else if (credit_next >= PRICE) begin
                    state_next = ST_VEND;
                end
            end
            ST_VEND: begin
                if (dispense_ack) begin
                    credit_next = credit_q - PRICE;
                    sale_next   = 1'b1;
                    state_next  = (credit_next != '0) ? ST_CHANGE : ST_COLLECT;
                end
            end
            ST_CHANGE: begin
                if (change_ack) begin
                    credit_next = credit_q - 1'b1;
                    if (credit_next == '0) begin
                        state_next = ST_COLLECT;
                    end
                end
            end
            default: begin
                state_next  = ST_COLLECT;
                credit_next = '0;
            end
        endcase
    end

    // State, credit and pulse registers; reset discards any credit.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_COLLECT;
            credit_q <= '0;
            reject_q <= 1'b0;
            sale_q   <= 1'b0;
        end else begin
            state    <= state_next;
            credit_q <= credit_next;
            reject_q <= reject_next;
            sale_q   <= sale_next;
        end
    end

    // Handshake and pulse outputs are forced low while reset is held so the
    // actuators see a quiet interface even before the first reset edge.
    assign coin_ready   = !reset && (state == ST_COLLECT);
    assign dispense_req = !reset && (state == ST_VEND);
    assign change_req   = !reset && (state == ST_CHANGE);
    assign coin_reject  = !reset && reject_q;
    assign sale_done    = !reset && sale_q;
    assign credit       = credit_q;

    a_coin_code_known: assert property (
        @(posedge clock) disable iff (reset) coin_valid |-> !$isunknown(coin_code)
    );

endmodule

// File: tb/tb_vend_sequencer.sv
// Self-checking bench for vend_sequencer: a directed vector table, a
// hand-written change-payout sequence, and randomized traffic compared
// against a behavioural model of the vending rules.
module tb_vend_sequencer;

    localparam int PRICE    = 3;
    localparam int CREDIT_W = 4;

    typedef struct {
        logic       rst;
        logic       cv;
        logic [1:0] cc;
        logic       cn;
        logic       da;
        logic       ca;
    } in_t;

    typedef struct {
        logic       rdy;
        logic       dreq;
        logic       creq;
        logic [7:0] cr;
        logic       rej;
        logic       sd;
    } out_t;

    typedef struct {
        in_t  i;
        out_t o;
    } vec_t;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic                coin_valid = 1'b0;
    logic [1:0]          coin_code = 2'b00;
    logic                coin_ready;
    logic                cancel = 1'b0;
    logic                dispense_req;
    logic                dispense_ack = 1'b0;
    logic                change_req;
    logic                change_ack = 1'b0;
    logic [CREDIT_W-1:0] credit;
    logic                coin_reject;
    logic                sale_done;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: credit as a plain integer, plus whether the
    // machine is busy dispensing or paying out.
    int m_credit  = 0;
    bit m_vending = 0;
    bit m_paying  = 0;
    bit m_reject  = 0;
    bit m_sale    = 0;
    bit m_rst     = 1;
    int coin_worth [4] = '{0, 1, 2, 5};

    vend_sequencer #(.PRICE_NICKELS(PRICE), .CREDIT_W(CREDIT_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .coin_valid  (coin_valid),
        .coin_code   (coin_code),
        .coin_ready  (coin_ready),
        .cancel      (cancel),
        .dispense_req(dispense_req),
        .dispense_ack(dispense_ack),
        .change_req  (change_req),
        .change_ack  (change_ack),
        .credit      (credit),
        .coin_reject (coin_reject),
        .sale_done   (sale_done)
    );

    always #5 clock = ~clock;

    function automatic in_t mk_in(bit rst, bit cv, logic [1:0] cc, bit cn, bit da, bit ca);
        in_t r;
        r.rst = rst; r.cv = cv; r.cc = cc; r.cn = cn; r.da = da; r.ca = ca;
        return r;
    endfunction

    function automatic vec_t mk(bit rst, bit cv, logic [1:0] cc, bit cn, bit da, bit ca,
                                bit rdy, bit dreq, bit creq, int cr, bit rej, bit sd);
        vec_t v;
        v.i = mk_in(rst, cv, cc, cn, da, ca);
        v.o.rdy = rdy; v.o.dreq = dreq; v.o.creq = creq;
        v.o.cr = 8'(cr); v.o.rej = rej; v.o.sd = sd;
        return v;
    endfunction

    function automatic void model_step(in_t i);
        m_rst = i.rst;
        if (i.rst) begin
            m_credit = 0; m_vending = 0; m_paying = 0; m_reject = 0; m_sale = 0;
            return;
        end
        m_reject = 0;
        m_sale   = 0;
        if (m_vending) begin
            if (i.da) begin
                m_credit  = m_credit - PRICE;
                m_sale    = 1;
                m_vending = 0;
                m_paying  = (m_credit > 0);
            end
        end else if (m_paying) begin
            if (i.ca) begin
                m_credit = m_credit - 1;
                if (m_credit == 0) m_paying = 0;
            end
        end else begin
            if (i.cv) begin
                if (i.cc == 2'b00) m_reject = 1;
                else m_credit = m_credit + coin_worth[i.cc];
            end
            if (i.cn && m_credit > 0) m_paying = 1;
            else if (m_credit >= PRICE) m_vending = 1;
        end
    endfunction

    function automatic out_t model_out();
        out_t o;
        o.rdy  = !m_rst && !m_vending && !m_paying;
        o.dreq = !m_rst && m_vending;
        o.creq = !m_rst && m_paying;
        o.cr   = 8'(m_credit);
        o.rej  = !m_rst && m_reject;
        o.sd   = !m_rst && m_sale;
        return o;
    endfunction

    task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, advance the model, and
    // return just after the next rising edge.
    task automatic applyStimulus(in_t i);
        @(negedge clock);
        reset        = i.rst;
        coin_valid   = i.cv;
        coin_code    = i.cc;
        cancel       = i.cn;
        dispense_ack = i.da;
        change_ack   = i.ca;
        model_step(i);
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(string tag, out_t exp);
        chk({tag, ".coin_ready"},   8'(coin_ready),   8'(exp.rdy));
        chk({tag, ".dispense_req"}, 8'(dispense_req), 8'(exp.dreq));
        chk({tag, ".change_req"},   8'(change_req),   8'(exp.creq));
        chk({tag, ".credit"},       8'(credit),       exp.cr);
        chk({tag, ".coin_reject"},  8'(coin_reject),  8'(exp.rej));
        chk({tag, ".sale_done"},    8'(sale_done),    8'(exp.sd));
    endtask

    initial begin
        vec_t tbl[$];
        int   handshakes;
        bit   done;

        // rst cv cc    cn da ca | rdy dreq creq cr rej sd
        tbl.push_back(mk(1, 0, 2'b00, 0, 0, 0,  0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 2'b00, 0, 0, 0,  1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2'b01, 0, 0, 0,  1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 2'b01, 0, 0, 0,  1, 0, 0, 2, 0, 0));
        tbl.push_back(mk(0, 1, 2'b01, 0, 0, 0,  0, 1, 0, 3, 0, 0));
        tbl.push_back(mk(0, 0, 2'b00, 0, 0, 0,  0, 1, 0, 3, 0, 0));
        tbl.push_back(mk(0, 0, 2'b00, 0, 1, 0,  1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 2'b00, 0, 0, 0,  1, 0, 0, 0, 0, 0));
        // invalid coin code
        tbl.push_back(mk(0, 1, 2'b00, 0, 0, 0,  1, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 2'b00, 0, 0, 0,  1, 0, 0, 0, 0, 0));
        // dime, then nickel with cancel: refund of 3
        tbl.push_back(mk(0, 1, 2'b10, 0, 0, 0,  1, 0, 0, 2, 0, 0));
        tbl.push_back(mk(0, 1, 2'b01, 1, 0, 0,  0, 0, 1, 3, 0, 0));
        tbl.push_back(mk(0, 0, 2'b00, 0, 0, 1,  0, 0, 1, 2, 0, 0));
        tbl.push_back(mk(0, 0, 2'b00, 1, 0, 1,  0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 2'b00, 0, 0, 0,  0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 2'b00, 0, 0, 1,  1, 0, 0, 0, 0, 0));
        // spurious acks and cancel with zero credit in COLLECT
        tbl.push_back(mk(0, 0, 2'b00, 0, 1, 1,  1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 2'b00, 1, 0, 0,  1, 0, 0, 0, 0, 0));
        // dime, quarter, coin held during VEND/CHANGE, reset mid-payout
        tbl.push_back(mk(0, 1, 2'b10, 0, 0, 0,  1, 0, 0, 2, 0, 0));
        tbl.push_back(mk(0, 1, 2'b11, 0, 0, 0,  0, 1, 0, 7, 0, 0));
        tbl.push_back(mk(0, 1, 2'b11, 1, 0, 1,  0, 1, 0, 7, 0, 0));
        tbl.push_back(mk(0, 1, 2'b11, 0, 1, 0,  0, 0, 1, 4, 0, 1));
        tbl.push_back(mk(0, 1, 2'b01, 0, 0, 1,  0, 0, 1, 3, 0, 0));
        tbl.push_back(mk(0, 0, 2'b00, 0, 1, 1,  0, 0, 1, 2, 0, 0));
        tbl.push_back(mk(1, 0, 2'b00, 0, 0, 1,  0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 2'b00, 0, 0, 0,  1, 0, 0, 0, 0, 0));

        for (int k = 0; k < tbl.size(); k++) begin
            applyStimulus(tbl[k].i);
            checkOutput($sformatf("vec%0d", k), tbl[k].o);
        end

        // Dime + quarter, acknowledge the dispense, then answer every
        // change request and count the nickels paid out.
        applyStimulus(mk_in(0, 1, 2'b10, 0, 0, 0));
        applyStimulus(mk_in(0, 1, 2'b11, 0, 0, 0));
        applyStimulus(mk_in(0, 0, 2'b00, 0, 1, 0));
        chk("payout.credit_after_sale", 8'(credit), 8'd4);
        handshakes = 0;
        done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (change_req) begin
                handshakes++;
                applyStimulus(mk_in(0, 0, 2'b00, 0, 0, 1));
            end else begin
                done = 1;
            end
        end
        chk("payout.handshakes", 8'(handshakes), 8'd4);
        chk("payout.credit_end", 8'(credit), 8'd0);
        chk("payout.coin_ready_end", 8'(coin_ready), 8'd1);
        if (!done) chk("payout.timeout", 8'd1, 8'd0);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            in_t r;
            r.rst = ($urandom_range(0, 99) == 0);
            r.cv  = $urandom_range(0, 1) == 1;
            r.cc  = 2'($urandom_range(0, 3));
            r.cn  = ($urandom_range(0, 9) == 0);
            r.da  = ($urandom_range(0, 2) == 0);
            r.ca  = ($urandom_range(0, 1) == 1);
            applyStimulus(r);
            checkOutput($sformatf("rand%0d", c), model_out());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
